pio_edge_in: RTL and testbench

Parametrised Avalon-MM input PIO for the SoC peripheral fabric. It samples up to 32 asynchronous input pins through a synchroniser and an optional per-bit debounce filter. Per bit, it captures rising and/or falling edges into sticky write-1-to-clear flags and raises a maskable level interrupt. It is the multi-bit, interrupt-capable successor of the single-bit edge-capture input port used for the Ethernet clock/status pins.

---
 rtl/pio_pkg.sv | 20 ++
 rtl/pio_in_filter.sv | 80 ++++++++
 rtl/pio_edge_in.sv | 98 +++++++++
 tb/tb_pio_edge_in.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared constants for the pio_edge_in input PIO: register word addresses,
// maximum port width and the debounce counter sizing helper.
package pio_pkg;

    localparam int PIO_MAX_WIDTH = 32;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_RISE    = 3'd4;
    localparam logic [2:0] ADDR_FALL    = 3'd5;

    // clog2(debounce+1), never narrower than one bit so the counter always exists.
    function automatic int cnt_width(input int debounce);
        int w;
        w = $clog2(debounce + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pio_in_filter.sv
// One input bit: synchroniser chain, optional debounce filter and the one-cycle
// delayed copy of the filtered value used for edge detection.
module pio_in_filter
    import pio_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic f,
    output logic f_prev
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_out;
    logic                   f_prev_q;
    logic                   f_prev_d;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pin};
        f_prev_d = f;
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign f_prev   = f_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            f_prev_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            f_prev_q <= f_prev_d;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            assign f = sync_out;
        end else begin : g_debounce
            localparam int            CW       = cnt_width(DEBOUNCE);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          f_q;
            logic          f_d;

            // Counter only runs while the synchronised pin disagrees with f;
            // any agreement restarts the stability window.
            always_comb begin
                cnt_d = '0;
                f_d   = f_q;
                if (sync_out != f_q) begin
                    if (cnt_q == CNT_LAST) begin
                        f_d = sync_out;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                    f_q   <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    f_q   <= f_d;
                end
            end

            assign f = f_q;
        end
    endgenerate

endmodule

// File: rtl/pio_edge_in.sv
// Avalon-MM input PIO with per-bit synchroniser/debounce, sticky W1C edge flags
// selectable for rising and/or falling edges, and a maskable level interrupt.
module pio_edge_in
    import pio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          SYNC_STAGES = 2,
    parameter int          DEBOUNCE    = 0,
    parameter logic [31:0] RISE_EN_RST = 32'hFFFF_FFFF,
    parameter logic [31:0] FALL_EN_RST = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] f_prev;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;

    logic [WIDTH-1:0] irqmask_q,  irqmask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] rise_q,     rise_d;
    logic [WIDTH-1:0] fall_q,     fall_d;

    logic [PIO_MAX_WIDTH-1:0] readdata_q, readdata_d;

    // Upper writedata bits beyond WIDTH carry no state.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        pio_in_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE)
        ) u_filter (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (in_port[gi]),
            .f       (f[gi]),
            .f_prev  (f_prev[gi])
        );
    end

    assign wr_en    = chipselect && !write_n;
    assign wdata    = writedata[WIDTH-1:0];
    assign edge_hit = (rise_q & f & ~f_prev) | (fall_q & ~f & f_prev);
    assign clr_mask = (wr_en && (address == ADDR_EDGE)) ? wdata : '0;

    // A fresh edge is OR-ed in after the clear so it survives a same-cycle W1C.
    always_comb begin
        irqmask_d  = (wr_en && (address == ADDR_IRQMASK)) ? wdata : irqmask_q;
        rise_d     = (wr_en && (address == ADDR_RISE))    ? wdata : rise_q;
        fall_d     = (wr_en && (address == ADDR_FALL))    ? wdata : fall_q;
        edge_cap_d = (edge_cap_q & ~clr_mask) | edge_hit;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = f;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGE:    readdata_d[WIDTH-1:0] = edge_cap_q;
            ADDR_RISE:    readdata_d[WIDTH-1:0] = rise_q;
            ADDR_FALL:    readdata_d[WIDTH-1:0] = fall_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q  <= '0;
            edge_cap_q <= '0;
            rise_q     <= RISE_EN_RST[WIDTH-1:0];
            fall_q     <= FALL_EN_RST[WIDTH-1:0];
            readdata_q <= '0;
        end else begin
            irqmask_q  <= irqmask_d;
            edge_cap_q <= edge_cap_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irqmask_q);

endmodule

// File: tb/tb_pio_edge_in.sv
// Bench for pio_edge_in: three instances (defaults, DEBOUNCE=4, WIDTH=3) on a shared
// bus, directed scenarios with fixed expectations plus a randomized model comparison.
module tb_pio_edge_in;
    import pio_pkg::*;

    localparam int NDUT = 3;

    logic            clk       = 1'b0;
    logic            reset_n   = 1'b1;
    logic [2:0]      address   = '0;
    logic            write_n   = 1'b1;
    logic [31:0]     writedata = '0;
    logic [NDUT-1:0] cs        = '0;
    logic [7:0]      in0       = '0;
    logic [7:0]      in1       = '0;
    logic [2:0]      in2       = '0;
    logic [31:0]     rd0, rd1, rd2;
    logic            irq0, irq1, irq2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_edge_in dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
        .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in0), .irq(irq0)
    );

    pio_edge_in #(.DEBOUNCE(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
        .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in1), .irq(irq1)
    );

    pio_edge_in #(.WIDTH(3)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]),
        .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in2), .irq(irq2)
    );

    // Reference model: pins delayed two sampling edges, f follows the delayed pin
    // once it has disagreed for DEBOUNCE consecutive cycles (immediately if 0).
    logic [31:0] m_d1 [NDUT];
    logic [31:0] m_d2 [NDUT];
    logic [31:0] m_f [NDUT];
    logic [31:0] m_fp [NDUT];
    logic [31:0] m_edge [NDUT];
    logic [31:0] m_mask [NDUT];
    logic [31:0] m_rise [NDUT];
    logic [31:0] m_fall [NDUT];
    logic [31:0] m_rd [NDUT];
    int          m_run [NDUT][32];

    function automatic int dbc_of(input int k);
        return (k == 1) ? 4 : 0;
    endfunction

    function automatic logic [31:0] wm_of(input int k);
        return (k == 2) ? 32'h7 : 32'hFF;
    endfunction

    function automatic logic [31:0] pin_of(input int k);
        case (k)
            0:       return {24'h0, in0};
            1:       return {24'h0, in1};
            default: return {29'h0, in2};
        endcase
    endfunction

    function automatic logic [31:0] rd_of(input int k);
        case (k)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    function automatic logic irq_of(input int k);
        case (k)
            0:       return irq0;
            1:       return irq1;
            default: return irq2;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_d1[k]   = '0;
            m_d2[k]   = '0;
            m_f[k]    = '0;
            m_fp[k]   = '0;
            m_edge[k] = '0;
            m_mask[k] = '0;
            m_rise[k] = 32'hFFFF_FFFF & wm_of(k);
            m_fall[k] = '0;
            m_rd[k]   = '0;
            for (int i = 0; i < 32; i++) m_run[k][i] = 0;
        end
    endtask

    always @(posedge clk) begin : model
        logic [31:0] wm, det, clr, pin;
        logic        wr;
        if (reset_n) begin
            for (int k = 0; k < NDUT; k++) begin
                wm  = wm_of(k);
                pin = pin_of(k) & wm;
                wr  = cs[k] && !write_n;
                det = ((m_rise[k] & m_f[k] & ~m_fp[k]) | (m_fall[k] & ~m_f[k] & m_fp[k])) & wm;
                case (address)
                    ADDR_DATA:    m_rd[k] = m_f[k];
                    ADDR_IRQMASK: m_rd[k] = m_mask[k];
                    ADDR_EDGE:    m_rd[k] = m_edge[k];
                    ADDR_RISE:    m_rd[k] = m_rise[k];
                    ADDR_FALL:    m_rd[k] = m_fall[k];
                    default:      m_rd[k] = '0;
                endcase
                clr = (wr && address == ADDR_EDGE) ? (writedata & wm) : '0;
                m_edge[k] = (m_edge[k] & ~clr) | det;
                if (wr && address == ADDR_IRQMASK) m_mask[k] = writedata & wm;
                if (wr && address == ADDR_RISE)    m_rise[k] = writedata & wm;
                if (wr && address == ADDR_FALL)    m_fall[k] = writedata & wm;
                m_fp[k] = m_f[k];
                if (dbc_of(k) == 0) begin
                    m_f[k] = m_d1[k];
                end else begin
                    for (int i = 0; i < 32; i++) begin
                        if (m_d2[k][i] != m_f[k][i]) begin
                            m_run[k][i] = m_run[k][i] + 1;
                            if (m_run[k][i] == dbc_of(k)) begin
                                m_f[k][i]   = m_d2[k][i];
                                m_run[k][i] = 0;
                            end
                        end else begin
                            m_run[k][i] = 0;
                        end
                    end
                end
                m_d2[k] = m_d1[k];
                m_d1[k] = pin;
            end
        end
    end

    task automatic bus_write(input int k, input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs        = '0;
        cs[k]     = 1'b1;
        @(negedge clk);
        write_n   = 1'b1;
        cs        = '0;
    endtask

    task automatic bus_read(input logic [2:0] a);
        address = a;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] exp8;
        logic [31:0] exp3;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a));
            exp8 = (a == 4) ? 32'hFF : 32'h0;
            exp3 = (a == 4) ? 32'h7  : 32'h0;
            checks++;
            if (rd0 !== exp8) begin
                errors++;
                $display("FAIL reset_rd0 addr=%0d got=%h exp=%h", a, rd0, exp8);
            end
            checks++;
            if (rd2 !== exp3) begin
                errors++;
                $display("FAIL reset_rd2 addr=%0d got=%h exp=%h", a, rd2, exp3);
            end
        end
        checks++;
        if ({irq0, irq1, irq2} !== 3'b000) begin
            errors++;
            $display("FAIL reset_irq got=%b exp=000", {irq0, irq1, irq2});
        end
        $display("test_reset done");
    endtask

    task automatic test_latency();
        address = ADDR_EDGE;
        in0     = 8'h05;
        repeat (3) @(negedge clk);
        checks++;
        if (rd0 !== 32'h0) begin
            errors++;
            $display("FAIL latency_before_edge3 got=%h exp=%h", rd0, 32'h0);
        end
        @(negedge clk);
        checks++;
        if (rd0 !== 32'h05) begin
            errors++;
            $display("FAIL latency_flag_edge3 got=%h exp=%h", rd0, 32'h05);
        end
        checks++;
        if (irq0 !== 1'b0) begin
            errors++;
            $display("FAIL latency_irq_masked got=%b exp=0", irq0);
        end
        bus_read(ADDR_DATA);
        checks++;
        if (rd0 !== 32'h05) begin
            errors++;
            $display("FAIL latency_data got=%h exp=%h", rd0, 32'h05);
        end
        $display("test_latency done");
    endtask

    task automatic test_irq();
        bus_write(0, ADDR_IRQMASK, 32'h04);
        bus_write(0, ADDR_EDGE, 32'h01);
        bus_read(ADDR_EDGE);
        checks++;
        if (rd0 !== 32'h04) begin
            errors++;
            $display("FAIL irq_w1c_partial got=%h exp=%h", rd0, 32'h04);
        end
        checks++;
        if (irq0 !== 1'b1) begin
            errors++;
            $display("FAIL irq_asserted got=%b exp=1", irq0);
        end
        bus_write(0, ADDR_EDGE, 32'h04);
        checks++;
        if (irq0 !== 1'b0) begin
            errors++;
            $display("FAIL irq_deassert got=%b exp=0", irq0);
        end
        $display("test_irq done");
    endtask

    task automatic test_fall();
        bus_write(0, ADDR_FALL, 32'hFF);
        bus_write(0, ADDR_RISE, 32'h00);
        in0 = 8'h85;
        repeat (5) @(negedge clk);
        bus_read(ADDR_EDGE);
        checks++;
        if (rd0 !== 32'h0) begin
            errors++;
            $display("FAIL fall_ignores_rise got=%h exp=%h", rd0, 32'h0);
        end
        in0 = 8'h05;
        repeat (5) @(negedge clk);
        bus_read(ADDR_EDGE);
        checks++;
        if (rd0 !== 32'h80) begin
            errors++;
            $display("FAIL fall_capture got=%h exp=%h", rd0, 32'h80);
        end
        bus_write(0, ADDR_RISE, 32'hFF);
        bus_write(0, ADDR_FALL, 32'h00);
        bus_write(0, ADDR_EDGE, 32'hFF);
        bus_write(0, ADDR_IRQMASK, 32'h00);
        $display("test_fall done");
    endtask

    task automatic test_back_to_back();
        in0 = 8'h08;
        repeat (6) @(negedge clk);
        bus_read(ADDR_EDGE);
        checks++;
        if (rd0 !== 32'h08) begin
            errors++;
            $display("FAIL b2b_setup got=%h exp=%h", rd0, 32'h08);
        end
        in0 = 8'h0C;
        repeat (2) @(negedge clk);
        bus_write(0, ADDR_EDGE, 32'h0C);
        bus_read(ADDR_EDGE);
        checks++;
        if (rd0 !== 32'h04) begin
            errors++;
            $display("FAIL b2b_edge_wins got=%h exp=%h", rd0, 32'h04);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_debounce();
        bus_write(1, ADDR_IRQMASK, 32'h01);
        in1 = 8'h01;
        repeat (3) @(negedge clk);
        in1 = 8'h00;
        repeat (10) @(negedge clk);
        bus_read(ADDR_DATA);
        checks++;
        if (rd1 !== 32'h0) begin
            errors++;
            $display("FAIL debounce_glitch_data got=%h exp=%h", rd1, 32'h0);
        end
        bus_read(ADDR_EDGE);
        checks++;
        if (rd1 !== 32'h0) begin
            errors++;
            $display("FAIL debounce_glitch_flag got=%h exp=%h", rd1, 32'h0);
        end
        in1 = 8'h01;
        repeat (6) @(negedge clk);
        in1 = 8'h00;
        checks++;
        if (irq1 !== 1'b0) begin
            errors++;
            $display("FAIL debounce_early got=%b exp=0", irq1);
        end
        @(negedge clk);
        checks++;
        if (irq1 !== 1'b1) begin
            errors++;
            $display("FAIL debounce_pulse_edge7 got=%b exp=1", irq1);
        end
        bus_write(1, ADDR_EDGE, 32'h01);
        checks++;
        if (irq1 !== 1'b0) begin
            errors++;
            $display("FAIL debounce_clear got=%b exp=0", irq1);
        end
        repeat (10) @(negedge clk);
        bus_write(1, ADDR_IRQMASK, 32'h00);
        $display("test_debounce done");
    endtask

    task automatic test_width();
        bus_write(2, ADDR_IRQMASK, 32'hFFFF_FFFF);
        bus_read(ADDR_IRQMASK);
        checks++;
        if (rd2 !== 32'h7) begin
            errors++;
            $display("FAIL width_mask got=%h exp=%h", rd2, 32'h7);
        end
        for (int a = 1; a < 8; a++) begin
            if (a == 1 || a == 6 || a == 7) begin
                bus_read(3'(a));
                checks++;
                if (rd0 !== 32'h0 || rd2 !== 32'h0) begin
                    errors++;
                    $display("FAIL width_unmapped addr=%0d got=%h/%h exp=0", a, rd0, rd2);
                end
            end
        end
        $display("test_width done");
    endtask

    task automatic test_reset_mid();
        bus_write(0, ADDR_IRQMASK, 32'h04);
        checks++;
        if (irq0 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre_irq got=%b exp=1", irq0);
        end
        in1 = 8'h01;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({irq0, irq1, irq2} !== 3'b000 || rd0 !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async got irq=%b rd0=%h exp irq=000 rd0=0", {irq0, irq1, irq2}, rd0);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_read(ADDR_EDGE);
        checks++;
        if (rd0 !== 32'h0 || rd1 !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_flags_cleared got=%h/%h exp=0", rd0, rd1);
        end
        repeat (10) @(negedge clk);
        bus_read(ADDR_EDGE);
        checks++;
        if (rd0 !== 32'h0C) begin
            errors++;
            $display("FAIL rstmid_release_rise0 got=%h exp=%h", rd0, 32'h0C);
        end
        checks++;
        if (rd1 !== 32'h01) begin
            errors++;
            $display("FAIL rstmid_release_rise1 got=%h exp=%h", rd1, 32'h01);
        end
        checks++;
        if (irq0 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_irq got=%b exp=0", irq0);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic exp_irq;
        for (int n = 0; n < 3000 && errors < 40; n++) begin
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (rd_of(k) !== m_rd[k]) begin
                    errors++;
                    $display("FAIL rand_rd dut=%0d cyc=%0d got=%h exp=%h", k, n, rd_of(k), m_rd[k]);
                end
                exp_irq = |(m_edge[k] & m_mask[k]);
                checks++;
                if (irq_of(k) !== exp_irq) begin
                    errors++;
                    $display("FAIL rand_irq dut=%0d cyc=%0d got=%b exp=%b", k, n, irq_of(k), exp_irq);
                end
            end
            cs      = '0;
            write_n = 1'b1;
            address = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                cs        = 3'($urandom_range(1, 7));
                write_n   = 1'b0;
                writedata = $urandom;
            end
            if ($urandom_range(0, 5) == 0) in0 = 8'($urandom);
            if ($urandom_range(0, 2) == 0) in1 = 8'($urandom);
            if ($urandom_range(0, 4) == 0) in2 = 3'($urandom);
            @(negedge clk);
        end
        cs      = '0;
        write_n = 1'b1;
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        #3;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_latency();
        test_irq();
        test_fall();
        test_back_to_back();
        test_debounce();
        test_width();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
